// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// encodings and the illegal-funct3 decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MERGE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        MERGE = ST_MERGE,
        RESP  = ST_RESP
    } lsu_state_e;

    // Reserved encodings, plus unsigned variants that only exist for loads.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic shared by the load and merge paths.
//   word_i       : memory word (load data or old word for a merge)
//   off_i        : byte offset within the word
//   funct3_i     : access size / signedness
//   wdata_i      : right-aligned store data
//   load_data_o  : extracted and extended load result
//   merge_data_o : word_i with the addressed lane(s) replaced by wdata_i
// Halfword lanes use off_i[1] only, so misaligned low bits are masked.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [4:0]  b_sh;
    logic [4:0]  h_sh;
    logic [7:0]  b_lane;
    logic [15:0] h_lane;
    logic [31:0] b_shifted;
    logic [31:0] h_shifted;

    assign b_sh      = {off_i, 3'b000};
    assign h_sh      = {off_i[1], 4'b0000};
    assign b_shifted = word_i >> b_sh;
    assign h_shifted = word_i >> h_sh;
    assign b_lane    = b_shifted[7:0];
    assign h_lane    = h_shifted[15:0];

    // Load extract with sign/zero extension.
    always_comb begin
        load_data_o = word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{b_lane[7]}}, b_lane};
            F3_BU:   load_data_o = {24'h0, b_lane};
            F3_H:    load_data_o = {{16{h_lane[15]}}, h_lane};
            F3_HU:   load_data_o = {16'h0, h_lane};
            default: load_data_o = word_i;
        endcase
    end

    // Store merge: clear the target lane, insert the new data.
    always_comb begin
        merge_data_o = wdata_i;
        case (funct3_i)
            F3_B: merge_data_o = (word_i & ~(32'h0000_00FF << b_sh))
                               | (32'(wdata_i[7:0]) << b_sh);
            F3_H: merge_data_o = (word_i & ~(32'h0000_FFFF << h_sh))
                               | (32'(wdata_i[15:0]) << h_sh);
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory.
// Byte/halfword/word loads with extension; sub-word stores via read-modify-write.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   req_*_i / req_ready_o     : request from execute (held until accepted)
//   resp_valid/rdata/err_o    : one-cycle registered completion
//   mem_we/re/addr/wdata_o    : combinational memory strobes (word index)
//   mem_rdata_i               : memory word, valid at the edge ending the read cycle
// Build option: define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word
// accesses into errors; otherwise the low address bits are masked.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_we_o,
    output logic        mem_re_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned AW = ADDR_W + 2;

    lsu_state_e     state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    old_q, old_d;
    logic           req_ready_q, req_ready_d;
    logic           resp_valid_q, resp_valid_d;
    logic           resp_err_q, resp_err_d;
    logic [31:0]    resp_rdata_q, resp_rdata_d;

    logic           mem_we_c, mem_re_c;
    logic [31:0]    mem_addr_c, mem_wdata_c;
    logic           err_c, misalign_c, range_c;
    logic [31:0]    req_idx_c;

    logic           sel_merge_c;
    logic [31:0]    al_word_c, al_load_c, al_merge_c;
    logic [1:0]     al_off_c;
    logic [2:0]     al_f3_c;

    // Request classification.
    assign req_idx_c = 32'(req_addr_i[AW-1:2]);
    assign range_c   = |(req_addr_i >> AW);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_c = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
                      || ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    assign err_c = f3_illegal(req_we_i, req_funct3_i) || range_c || misalign_c;

    // The single lane unit sees the live request in IDLE and the captured one in MERGE.
    assign sel_merge_c = (state_q == MERGE);
    assign al_word_c   = sel_merge_c ? old_q        : mem_rdata_i;
    assign al_off_c    = sel_merge_c ? addr_q[1:0]  : req_addr_i[1:0];
    assign al_f3_c     = sel_merge_c ? funct3_q     : req_funct3_i;

    lsu_align u_align (
        .word_i       (al_word_c),
        .off_i        (al_off_c),
        .funct3_i     (al_f3_c),
        .wdata_i      (wdata_q),
        .load_data_o  (al_load_c),
        .merge_data_o (al_merge_c)
    );

    // Next-state, capture and memory strobe logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        old_d        = old_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_we_c     = 1'b0;
        mem_re_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i[AW-1:0];
                    funct3_d = req_funct3_i;
                    wdata_d  = req_wdata_i;
                    if (err_c) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (!req_we_i) begin
                        mem_re_c     = 1'b1;
                        mem_addr_c   = req_idx_c;
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = al_load_c;
                    end else if (req_funct3_i == F3_W) begin
                        mem_we_c     = 1'b1;
                        mem_addr_c   = req_idx_c;
                        mem_wdata_c  = req_wdata_i;
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        mem_re_c   = 1'b1;
                        mem_addr_c = req_idx_c;
                        old_d      = mem_rdata_i;
                        state_d    = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_we_c     = 1'b1;
                mem_addr_c   = 32'(addr_q[AW-1:2]);
                mem_wdata_c  = al_merge_c;
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // Reset must silence the memory in the same cycle, so a MERGE write is dropped.
    assign mem_we_o    = mem_we_c & ~rst_i;
    assign mem_re_o    = mem_re_c & ~rst_i;
    assign mem_addr_o  = rst_i ? '0 : mem_addr_c;
    assign mem_wdata_o = rst_i ? '0 : mem_wdata_c;

    // State and capture registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            old_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            old_q        <= old_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a combinational-read word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [256];
    logic        tb_wr = 1'b0;
    logic [7:0]  tb_waddr = 8'h0;
    logic [31:0] tb_wdata = 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_we_o     (mem_we),
        .mem_re_o     (mem_re),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (tb_wr)       mem[tb_waddr] <= tb_wdata;
        else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_resp: got rdata %h err %b with empty scoreboard", resp_rdata, resp_err);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
        if (mem_we) chk("we_re_exclusive", 32'(mem_re), 32'h0);
    end

    // Drive one request once the unit is ready; checks the accept-cycle strobes.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err,
                         input logic exp_re, input logic exp_we, input logic [31:0] exp_maddr,
                         input bit push, output int acc);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'(req_ready), 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
        chk("accept_mem_re", 32'(mem_re), 32'(exp_re));
        chk("accept_mem_we", 32'(mem_we), 32'(exp_we));
        chk("accept_mem_addr", mem_addr, exp_maddr);
        if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            sb.push_back(e);
        end
        @(posedge clk);
        acc = cyc;
        #1 req_valid = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_wr    = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(negedge clk);
        tb_wr    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, a1;
        rst = 1'b1;
        preload(8'd5, 32'h8040_20F0);
        preload(8'd3, 32'h1122_3344);
        preload(8'd2, 32'h1234_5678);
        preload(8'd8, 32'h0BAD_F00D);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        rst = 1'b0;

        // Loads from word 5 = 0x8040_20F0.
        issue(1'b0, 3'b000, 32'h15, 32'h0, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 32'd5, 1'b1, a0);
        issue(1'b0, 3'b000, 32'h17, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1, 1'b0, 32'd5, 1'b1, a0);
        issue(1'b0, 3'b101, 32'h16, 32'h0, 32'h0000_8040, 1'b0, 1'b1, 1'b0, 32'd5, 1'b1, a0);
        issue(1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF_8040, 1'b0, 1'b1, 1'b0, 32'd5, 1'b1, a0);
        issue(1'b0, 3'b001, 32'h14, 32'h0, 32'h0000_20F0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b1, a0);
        issue(1'b0, 3'b100, 32'h17, 32'h0, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 32'd5, 1'b1, a0);
        issue(1'b0, 3'b010, 32'h14, 32'h0, 32'h8040_20F0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b1, a0);

        // SB read-modify-write into word 3 with ready/valid timing.
        issue(1'b1, 3'b000, 32'h0D, 32'hFFFF_FFAB, 32'h0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b1, a0);
        @(negedge clk);
        chk("sb_merge_ready", 32'(req_ready), 32'h0);
        chk("sb_merge_we", 32'(mem_we), 32'h1);
        chk("sb_merge_valid", 32'(resp_valid), 32'h0);
        @(negedge clk);
        chk("sb_resp_ready", 32'(req_ready), 32'h0);
        chk("sb_resp_valid", 32'(resp_valid), 32'h1);
        chk("sb_word3", mem[3], 32'h1122_AB44);
        @(negedge clk);
        chk("sb_ready_back", 32'(req_ready), 32'h1);

        // SW then LW back-to-back.
        issue(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b1, 32'd8, 1'b1, a0);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'd8, 1'b1, a1);
        chk("b2b_gap", 32'(a1 - a0), 32'd2);

        // SH into upper half of word 2, SB into top byte of word 3.
        issue(1'b1, 3'b001, 32'h0A, 32'h0000_CAFE, 32'h0, 1'b0, 1'b1, 1'b0, 32'd2, 1'b1, a0);
        issue(1'b0, 3'b010, 32'h08, 32'h0, 32'hCAFE_5678, 1'b0, 1'b1, 1'b0, 32'd2, 1'b1, a0);
        issue(1'b1, 3'b000, 32'h0F, 32'h0000_0077, 32'h0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b1, a0);
        issue(1'b0, 3'b010, 32'h0C, 32'h0, 32'h7722_AB44, 1'b0, 1'b1, 1'b0, 32'd3, 1'b1, a0);

        // Misaligned LW depends on the build option.
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, a0);
`else
        issue(1'b0, 3'b010, 32'h22, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'd8, 1'b1, a0);
`endif
        // Illegal funct3, out of range, store with unsigned funct3.
        issue(1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, a0);
        issue(1'b0, 3'b000, 32'h400, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, a0);
        issue(1'b1, 3'b100, 32'h0C, 32'h55, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, a0);

        // Reset during MERGE aborts the write.
        issue(1'b1, 3'b001, 32'h0E, 32'h0000_9999, 32'h0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0, a0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_merge_we", 32'(mem_we), 32'h0);
        chk("rst_merge_re", 32'(mem_re), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_valid", 32'(resp_valid), 32'h0);
        chk("post_rst_word3", mem[3], 32'h7722_AB44);
        issue(1'b0, 3'b010, 32'h0C, 32'h0, 32'h7722_AB44, 1'b0, 1'b1, 1'b0, 32'd3, 1'b1, a0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
